// File: rtl/fwd_pkg.sv
// fwd_pkg: shared select codes, pipeline tag-entry type and liveness helper for the forwarding controller
package fwd_pkg;
    localparam int REG_W = 5;
    localparam logic [2:0] SEL_RF  = 3'b000;
    localparam logic [2:0] SEL_EX  = 3'b001;
    localparam logic [2:0] SEL_MEM = 3'b010;
    localparam logic [2:0] SEL_WB  = 3'b011;
    localparam logic [2:0] SEL_IMM = 3'b100;
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             we;
        logic             load;
    } tag_t;
    // r0 is hardwired zero, so an entry only forwards when it writes a real register
    function automatic logic live(input tag_t t);
        return t.we && (t.rd != '0);
    endfunction
endpackage

// File: rtl/fwd_sel_ctrl_if.sv
// fwd_sel_ctrl_if: decode-side bundle into the forwarding controller
//   master: drives hold, flush and the decode fields; receives sel_a, sel_b, stall
//   slave : the controller side
interface fwd_sel_ctrl_if #(parameter int REG_BITS = 5);
    logic                hold;
    logic                flush;
    logic                d_valid;
    logic [REG_BITS-1:0] d_rs;
    logic [REG_BITS-1:0] d_rt;
    logic                d_use_rs;
    logic                d_use_rt;
    logic                d_use_imm;
    logic [REG_BITS-1:0] d_rd;
    logic                d_we;
    logic                d_load;
    logic [2:0]          sel_a;
    logic [2:0]          sel_b;
    logic                stall;
    modport master (
        output hold, flush, d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_use_imm, d_rd, d_we, d_load,
        input  sel_a, sel_b, stall
    );
    modport slave (
        input  hold, flush, d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_use_imm, d_rd, d_we, d_load,
        output sel_a, sel_b, stall
    );
endinterface

// File: rtl/fwd_match.sv
// fwd_match: priority compare of one source specifier against the E, M, W tag entries
//   src, used  : source specifier and whether it is read
//   e, m, w    : tag entries, youngest first
//   code       : SEL_EX / SEL_MEM / SEL_WB / SEL_RF
//   load_hit   : source matches a live load sitting in E
//   FWD_WB_EN  : when defined, W matches forward from the late latch; otherwise the
//                W comparator is absent and the register file write-through covers W
module fwd_match
    import fwd_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             used,
    input  tag_t             e,
    input  tag_t             m,
    input  tag_t             w,
    output logic [2:0]       code,
    output logic             load_hit
);
    logic hit_e, hit_m, hit_w;
    assign hit_e = used && live(e) && (src == e.rd);
    assign hit_m = used && live(m) && (src == m.rd);
`ifdef FWD_WB_EN
    assign hit_w = used && live(w) && (src == w.rd);
`else
    logic unused_w;
    assign unused_w = ^w;
    assign hit_w    = 1'b0;
`endif
    assign code     = hit_e ? SEL_EX : hit_m ? SEL_MEM : hit_w ? SEL_WB : SEL_RF;
    assign load_hit = hit_e && e.load;
endmodule

// File: rtl/fwd_sel_ctrl.sv
// fwd_sel_ctrl: operand-forwarding controller with load-use stall and bubble insertion
//   clk   : pipeline clock, rising edge
//   reset : asynchronous, active-high; clears tags and selects
//   bus   : fwd_sel_ctrl_if.slave (hold, flush, decode fields in; sel_a, sel_b, stall out)
//   FWD_WB_EN : enables W-stage forwarding (code 011), see fwd_match
//   REG_BITS must not exceed fwd_pkg::REG_W
module fwd_sel_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_BITS = 5
)(
    input  logic          clk,
    input  logic          reset,
    fwd_sel_ctrl_if.slave bus
);
    tag_t                e, m, w;
    logic [2:0]          sel_a_q, sel_b_q, code_a, code_b;
    logic                lh_a, lh_b, bubble;
    logic [REG_BITS-1:0] rs_in, rt_in, rd_in;
    assign rs_in = bus.d_rs;
    assign rt_in = bus.d_rt;
    assign rd_in = bus.d_rd;
    fwd_match u_match_a (
        .src(REG_W'(rs_in)), .used(bus.d_use_rs),
        .e(e), .m(m), .w(w), .code(code_a), .load_hit(lh_a)
    );
    // an immediate operand B reads no register, so it can neither forward nor stall
    fwd_match u_match_b (
        .src(REG_W'(rt_in)), .used(bus.d_use_rt && !bus.d_use_imm),
        .e(e), .m(m), .w(w), .code(code_b), .load_hit(lh_b)
    );
    assign bus.stall = bus.d_valid && (lh_a || lh_b);
    assign bubble    = bus.flush || bus.stall || !bus.d_valid;
    assign bus.sel_a = sel_a_q;
    assign bus.sel_b = sel_b_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e       <= '0;
            m       <= '0;
            w       <= '0;
            sel_a_q <= SEL_RF;
            sel_b_q <= SEL_RF;
        end else if (!bus.hold) begin
            w       <= m;
            m       <= e;
            e       <= bubble ? '0 : tag_t'{rd: REG_W'(rd_in), we: bus.d_we, load: bus.d_load};
            sel_a_q <= bubble ? SEL_RF : code_a;
            sel_b_q <= bubble ? SEL_RF : bus.d_use_imm ? SEL_IMM : code_b;
        end
    end
endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// tb_fwd_sel_ctrl: table-driven scoreboard bench for fwd_sel_ctrl
module tb_fwd_sel_ctrl;
    import fwd_pkg::*;
`ifdef FWD_WB_EN
    localparam logic [2:0] SW = SEL_WB;
`else
    localparam logic [2:0] SW = SEL_RF;
`endif
    typedef struct {
        logic v; logic [4:0] rs, rt; logic urs, urt, imm; logic [4:0] rd;
        logic we, ld, fl, hd, xs; logic [2:0] xa, xb;
    } vec_t;
    typedef struct { logic [2:0] a, b; } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fwd_sel_ctrl_if #(.REG_BITS(5)) bus();
    fwd_sel_ctrl #(.REG_BITS(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    vec_t tbl[25];
    exp_t q[$];
    int errs = 0;
    int checks = 0;

    function automatic vec_t mk(input logic v, input int rs, input int rt,
                                input logic urs, input logic urt, input logic imm,
                                input int rd, input logic we, input logic ld,
                                input logic fl, input logic hd, input logic xs,
                                input logic [2:0] xa, input logic [2:0] xb);
        vec_t t;
        t.v = v; t.rs = 5'(rs); t.rt = 5'(rt); t.urs = urs; t.urt = urt; t.imm = imm;
        t.rd = 5'(rd); t.we = we; t.ld = ld; t.fl = fl; t.hd = hd; t.xs = xs; t.xa = xa; t.xb = xb;
        return t;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.d_valid = t.v; bus.d_rs = t.rs; bus.d_rt = t.rt; bus.d_use_rs = t.urs;
        bus.d_use_rt = t.urt; bus.d_use_imm = t.imm; bus.d_rd = t.rd; bus.d_we = t.we;
        bus.d_load = t.ld; bus.flush = t.fl; bus.hold = t.hd;
    endtask

    task automatic run(input vec_t t, input string n);
        exp_t x;
        @(negedge clk);
        drive(t);
        #1 chk({n, ".stall"}, 32'(bus.stall), 32'(t.xs));
        q.push_back('{t.xa, t.xb});
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk({n, ".queue"}, 32'(0), 32'(1));
        end else begin
            x = q.pop_front();
            chk({n, ".sel_a"}, 32'(bus.sel_a), 32'(x.a));
            chk({n, ".sel_b"}, 32'(bus.sel_b), 32'(x.b));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, SEL_RF, SEL_RF));
        tbl[0]  = mk(1, 1, 2, 1, 1, 0, 3, 1, 0, 0, 0, 0, SEL_RF, SEL_RF);
        tbl[1]  = mk(1, 3, 2, 1, 1, 0, 8, 1, 0, 0, 0, 0, SEL_EX, SEL_RF);
        tbl[2]  = mk(1, 1, 2, 1, 1, 0, 9, 1, 0, 0, 0, 0, SEL_RF, SEL_RF);
        tbl[3]  = mk(1, 8, 3, 1, 1, 0, 10, 1, 0, 0, 0, 0, SEL_MEM, SW);
        tbl[4]  = mk(1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, SEL_RF, SEL_RF);
        tbl[5]  = mk(1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, SEL_RF, SEL_RF);
        tbl[6]  = mk(1, 10, 7, 1, 1, 0, 11, 1, 0, 0, 0, 0, SW, SEL_EX);
        tbl[7]  = mk(1, 7, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0, SEL_MEM, SEL_IMM);
        tbl[8]  = mk(1, 11, 0, 1, 0, 1, 4, 1, 1, 0, 0, 0, SEL_MEM, SEL_IMM);
        tbl[9]  = mk(1, 4, 2, 1, 1, 0, 5, 1, 0, 0, 0, 1, SEL_RF, SEL_RF);
        tbl[10] = mk(1, 4, 2, 1, 1, 0, 5, 1, 0, 0, 0, 0, SEL_MEM, SEL_RF);
        tbl[11] = mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, SEL_RF, SEL_RF);
        tbl[12] = mk(1, 0, 0, 1, 1, 0, 6, 1, 0, 0, 0, 0, SEL_RF, SEL_RF);
        tbl[13] = mk(1, 6, 5, 1, 1, 0, 12, 1, 0, 0, 1, 0, SEL_RF, SEL_RF);
        tbl[14] = mk(1, 6, 5, 1, 1, 0, 12, 1, 0, 0, 1, 0, SEL_RF, SEL_RF);
        tbl[15] = mk(1, 6, 5, 1, 1, 0, 12, 1, 0, 0, 1, 0, SEL_RF, SEL_RF);
        tbl[16] = mk(1, 6, 5, 1, 1, 0, 12, 1, 0, 0, 0, 0, SEL_EX, SW);
        tbl[17] = mk(1, 0, 0, 0, 0, 0, 13, 1, 1, 0, 0, 0, SEL_RF, SEL_RF);
        tbl[18] = mk(1, 13, 0, 1, 0, 0, 14, 1, 0, 1, 0, 1, SEL_RF, SEL_RF);
        tbl[19] = mk(1, 13, 12, 1, 1, 0, 14, 1, 0, 0, 0, 0, SEL_MEM, SW);
        tbl[20] = mk(1, 14, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, SEL_RF, SEL_RF);
        tbl[21] = mk(1, 14, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, SEL_MEM, SEL_RF);
        tbl[22] = mk(1, 0, 0, 0, 0, 0, 15, 1, 1, 0, 0, 0, SEL_RF, SEL_RF);
        tbl[23] = mk(0, 15, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, SEL_RF, SEL_RF);
        tbl[24] = mk(1, 15, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, SEL_MEM, SEL_RF);

        #1;
        chk("reset.sel_a", 32'(bus.sel_a), 32'(SEL_RF));
        chk("reset.sel_b", 32'(bus.sel_b), 32'(SEL_RF));
        chk("reset.stall", 32'(bus.stall), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 25; i++) run(tbl[i], $sformatf("v%0d", i));

        run(mk(1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, SEL_RF, SEL_RF), "rst_w5");
        run(mk(1, 5, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, SEL_EX, SEL_RF), "rst_lw5");
        @(negedge clk);
        drive(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, SEL_RF, SEL_RF));
        #1 chk("rst_pre.stall", 32'(bus.stall), 32'(1));
        #1 reset = 1'b1;
        #1;
        chk("rst_async.sel_a", 32'(bus.sel_a), 32'(SEL_RF));
        chk("rst_async.sel_b", 32'(bus.sel_b), 32'(SEL_RF));
        chk("rst_async.stall", 32'(bus.stall), 32'(0));
        @(negedge clk) reset = 1'b0;
        run(mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, SEL_RF, SEL_RF), "rst_read5");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/fwd_sel_ctrl.md
# fwd_sel_ctrl

Operand-forwarding controller for the integer pipeline. Tracks the destination-register tags of the instructions in the EX, MEM and WB stages and produces the registered 3-bit select codes that steer the two 32-bit five-way operand multiplexers feeding the ALU. It also detects load-use hazards and raises a one-cycle decode stall with bubble insertion. Placement: between decode and the operand muxes, directly upstream of them.

## Interface

Parameters:
- REG_BITS, 5, width of a register specifier

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- hold  in  1  external freeze, e.g. cache miss; all state holds
- flush  in  1  kills the instruction entering EX; a bubble enters instead
- d_valid  in  1  decode slot holds a real instruction
- d_rs, d_rt  in  REG_BITS  source specifiers
- d_use_rs, d_use_rt  in  1  the source is actually read
- d_use_imm  in  1  operand B is the immediate
- d_rd  in  REG_BITS  destination specifier
- d_we  in  1  instruction writes d_rd
- d_load  in  1  instruction is a load
- sel_a, sel_b  out  3  registered mux selects for operand A and operand B in EX
- stall  out  1  combinational load-use stall to decode and fetch

## Operation

- Tag pipe: three entries E, M and W, each {rd, we, load}. An entry is live only if we=1 and rd≠0.
- Select codes:
  - 000: register file
  - 001: EX/MEM ALU result
  - 010: MEM/WB result
  - 011: WB late latch
  - 100: immediate (sel_b only)
  - 101–111: never driven
- Match rule for a used source s:
  - Compare s against the live E entry, then M, then W.
  - The first hit wins (youngest producer), giving 001, 010 or 011 respectively.
  - No hit gives 000. s=0 always gives 000.
- sel_b: d_use_imm=1 forces 100 and overrides any match. d_use_rt is ignored in that case.
- Load-use stall: stall = d_valid & E.live & E.load & ((d_use_rs & d_rs==E.rd) | (d_use_rt & ~d_use_imm & d_rt==E.rd)).
- Update at each rising edge when hold=0:
  - W←M and M←E.
  - If flush, stall or !d_valid: E←{0,0,0} and sel_a = sel_b = 000.
  - Otherwise: E←{d_rd, d_we, d_load}, and sel_a/sel_b are computed from the pre-edge E/M/W.
- hold=1: E, M, W, sel_a and sel_b all hold. stall is still evaluated combinationally.
- flush together with stall: flush governs. A bubble enters EX.

## Timing

- Reset values: E, M and W entries cleared; sel_a = sel_b = 000; stall = 0.
- Reset mid-operation: all tags are cleared immediately and asynchronously; no stale forwarding survives.
- Select latency: selects for the instruction in decode at edge n are valid in EX during cycle n+1.
- Load-use: exactly one stall cycle.
  - At the next edge the load moves to M.
  - The retried consumer then matches M and gets 010.
- stall depends only on the current decode inputs and the registered E entry. There is no combinational path from hold or flush to stall.

## Configuration

- FWD_WB_EN defined: W-stage matches produce 011, using the late latch in the datapath.
- FWD_WB_EN undefined:
  - The W comparator is removed and W matches produce 000.
  - The register file must then provide same-cycle write-through.
  - Code 011 is never driven.

## Structure

- Package fwd_pkg holds:
  - constants SEL_RF=3'b000, SEL_EX=3'b001, SEL_MEM=3'b010, SEL_WB=3'b011, SEL_IMM=3'b100
  - the tag-entry struct/typedef {rd, we, load}
- Sub-module fwd_match:
  - Combinational priority compare of one source against the E, M and W entries, returning a 3-bit code and a load-hit flag.
  - Instantiated twice, once for A and once for B.

## Test plan

- Reset: assert reset mid-stream with E.rd=5 live → sel_a=sel_b=000, stall=0 immediately; then a read of r5 gives 000.
- Back-to-back ALU: add r3 followed by sub reading rs=r3 → sel_a=001 in the consumer's EX cycle; with one unrelated instruction between them → 010; with two between (FWD_WB_EN) → 011.
- Youngest wins: E and M both write r7, consumer reads r7 on rt → sel_b=001. Consumer uses imm with rt=r7 → sel_b=100.
- Load-use: lw r4, then add rs=r4 → stall=1 for exactly one cycle and a bubble in EX (sel 000); the retried add gets sel_a=010.
- r0 and hold:
  - A writer of r0 followed by a reader of r0 → 000, no stall.
  - hold=1 for 3 cycles during a pending forward → sel and tags unchanged, and the forward completes after release.
- Flush with stall: flush=1 in the same cycle stall=1 → E gets a bubble, and M/W advance normally.
